// File: rtl/byte_mem_responder.sv
// rtl/byte_mem_responder.sv - four-bank byte memory with 1-cycle reads and byte-serial writes
// Bank k holds bytes with addr[1:0]==k, so any 4-byte window is one row per bank.
module byte_mem_responder #(
   parameter int ADDR_BITS = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [1:0]  write,
   input  logic [7:0]  d0,
   input  logic [7:0]  d1,
   input  logic [7:0]  d2,
   input  logic [7:0]  d3,
   output logic [7:0]  q0,
   output logic [7:0]  q1,
   output logic [7:0]  q2,
   output logic [7:0]  q3,
   output logic        done,
   output logic        error
);
   localparam int ROWS = 2 ** (ADDR_BITS - 2);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE, S_REJECT} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [31:0]            wd_q, wd_d;
   logic [1:0]             cnt_q, cnt_d;
   logic [1:0]             last_q, last_d;
   logic [31:0]            q_q, q_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;

   logic [7:0]             mem_q [4][ROWS];

   logic [ADDR_BITS-1:0]   a_in;
   logic                   out_of_range;
   logic                   illegal;
   logic [ADDR_BITS-1:0]   rd_addr [4];
   logic [ADDR_BITS-1:0]   wr_addr;
   logic                   mem_we;
   logic [7:0]             mem_wd;

   assign a_in         = address[ADDR_BITS-1:0];
   assign out_of_range = |address[31:ADDR_BITS];
   assign illegal      = out_of_range
                       || (write == 2'b10 && address[0])
                       || (write == 2'b11 && address[1:0] != 2'b00);

   // q_q[7:0] is byte A (little-endian), each byte address wraps inside the decoded space
   always_comb begin
      q_d = '0;
      for (int i = 0; i < 4; i++) begin
         rd_addr[i] = a_in + ADDR_BITS'(i);
         q_d[8*i +: 8] = mem_q[rd_addr[i][1:0]][rd_addr[i][ADDR_BITS-1:2]];
      end
      if (out_of_range) q_d = '0;
   end

   assign wr_addr = addr_q + ADDR_BITS'(cnt_q);
   assign mem_wd  = wd_q[{cnt_q, 3'b000} +: 8];
   assign mem_we  = (state_q == S_WRITE) && !rst;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wd_d    = wd_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      done_d  = 1'b0;
      error_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (write != 2'b00) begin
               if (illegal) begin
                  state_d = S_REJECT;
                  done_d  = 1'b1;
                  error_d = 1'b1;
               end else begin
                  state_d = S_WRITE;
                  addr_d  = a_in;
                  wd_d    = {d0, d1, d2, d3};
                  cnt_d   = 2'd0;
                  last_d  = (write == 2'b01) ? 2'd0 : (write == 2'b10) ? 2'd1 : 2'd3;
               end
            end else begin
               error_d = out_of_range;
            end
         end
         S_WRITE: begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == last_q) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end
         end
         S_DONE: begin
            if (write == 2'b00) state_d = S_IDLE;
            else                done_d  = 1'b1;
         end
         S_REJECT: begin
            if (write == 2'b00) begin
               state_d = S_IDLE;
            end else begin
               done_d  = 1'b1;
               error_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wd_q    <= '0;
         cnt_q   <= '0;
         last_q  <= '0;
         q_q     <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         q_q     <= q_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   // Bank contents survive reset; only an in-flight commit is suppressed
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_addr[1:0]][wr_addr[ADDR_BITS-1:2]] <= mem_wd;
   end

   assign q3    = q_q[7:0];
   assign q2    = q_q[15:8];
   assign q1    = q_q[23:16];
   assign q0    = q_q[31:24];
   assign done  = done_q;
   assign error = error_q;
endmodule

// File: tb/tb_byte_mem_responder.sv
// tb/tb_byte_mem_responder.sv - directed self-checking bench for byte_mem_responder
module tb_byte_mem_responder;
   logic        clk;
   logic        rst;
   logic [31:0] address;
   logic [1:0]  write;
   logic [7:0]  d0, d1, d2, d3;
   logic [7:0]  q0, q1, q2, q3;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;
   int cyc;

   byte_mem_responder #(.ADDR_BITS(12)) dut (
      .clk(clk), .rst(rst), .address(address), .write(write),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .q0(q0), .q1(q1), .q2(q2), .q3(q3),
      .done(done), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] data);
      address = a;
      write   = sz;
      {d0, d1, d2, d3} = data;
   endtask

   // cycles counted from the acceptance edge; -1 means done never rose
   task automatic wait_done(output int n);
      n = -1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (done === 1'b1) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic release_write();
      write = 2'b00;
      step();
      chk("done_clear", {31'd0, done}, 32'd0);
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      address = a;
      step();
      chk(tag, {q0, q1, q2, q3}, exp);
   endtask

   initial begin
      rst = 1'b1;
      address = 32'h0;
      write = 2'b00;
      {d0, d1, d2, d3} = 32'h0;
      step();
      chk("reset_q", {q0, q1, q2, q3}, 32'h0);
      step();
      rst = 1'b0;
      step();
      step();
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_error", {31'd0, error}, 32'd0);

      start_write(32'h14, 2'b01, 32'h0000_005A);
      wait_done(cyc);
      chk("byte_latency", cyc, 2);
      release_write();

      start_write(32'h20, 2'b11, 32'h1122_3344);
      wait_done(cyc);
      chk("word20_latency", cyc, 5);
      release_write();

      start_write(32'h10, 2'b11, 32'hDEAD_BEEF);
      wait_done(cyc);
      chk("word10_latency", cyc, 5);
      release_write();
      rd("read_10", 32'h10, 32'hDEAD_BEEF);
      rd("read_11", 32'h11, 32'h5ADE_ADBE);
      chk("read_err", {31'd0, error}, 32'd0);

      start_write(32'h12, 2'b10, 32'h0000_1234);
      wait_done(cyc);
      chk("half_latency", cyc, 3);
      release_write();
      rd("read_after_half", 32'h10, 32'h1234_BEEF);

      start_write(32'h13, 2'b10, 32'h0000_FFFF);
      step();
      chk("rej13_done", {31'd0, done}, 32'd1);
      chk("rej13_error", {31'd0, error}, 32'd1);
      step();
      chk("rej13_hold", {30'd0, done, error}, 32'd3);
      write = 2'b00;
      step();
      chk("rej13_clear", {30'd0, done, error}, 32'd0);
      rd("rej13_mem", 32'h10, 32'h1234_BEEF);

      start_write(32'h12, 2'b11, 32'hFFFF_FFFF);
      step();
      chk("rej12_flags", {30'd0, done, error}, 32'd3);
      write = 2'b00;
      step();
      chk("rej12_clear", {30'd0, done, error}, 32'd0);
      rd("rej12_mem", 32'h10, 32'h1234_BEEF);

      start_write(32'h1000, 2'b11, 32'hFFFF_FFFF);
      step();
      chk("oor_flags", {30'd0, done, error}, 32'd3);
      write = 2'b00;
      step();
      step();
      chk("oor_read_q", {q0, q1, q2, q3}, 32'h0);
      chk("oor_read_flags", {30'd0, done, error}, 32'd1);

      start_write(32'hFFC, 2'b11, 32'h9988_7766);
      wait_done(cyc);
      chk("ffc_latency", cyc, 5);
      release_write();
      start_write(32'h0, 2'b11, 32'h4433_2211);
      wait_done(cyc);
      chk("zero_latency", cyc, 5);
      release_write();
      rd("wrap_ffe", 32'hFFE, 32'h2211_9988);

      start_write(32'h30, 2'b11, 32'h0102_0304);
      step();
      write = 2'b00;
      address = 32'h0;
      {d0, d1, d2, d3} = 32'hFFFF_FFFF;
      cyc = -1;
      for (int k = 2; k <= 20; k++) begin
         step();
         if (done === 1'b1) begin
            cyc = k;
            break;
         end
      end
      chk("drop_latency", cyc, 5);
      step();
      chk("drop_done_pulse", {31'd0, done}, 32'd0);
      rd("drop_mem", 32'h30, 32'h0102_0304);

      start_write(32'h20, 2'b11, 32'hAABB_CCDD);
      step();
      step();
      step();
      rst = 1'b1;
      write = 2'b00;
      step();
      rst = 1'b0;
      chk("abort_done", {31'd0, done}, 32'd0);
      step();
      chk("abort_idle", {30'd0, done, error}, 32'd0);
      rd("abort_mem", 32'h20, 32'h1122_CCDD);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
